// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM timer bank: write-select codes, ctrl bit positions
// and the channel-index width helper.
package pwm_timer_pkg;

    typedef enum logic [1:0] {
        WR_SEL_PERIOD = 2'd0,
        WR_SEL_HOLD   = 2'd1,
        WR_SEL_CTRL   = 2'd2,
        WR_SEL_NONE   = 2'd3
    } wr_sel_e;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_POL_BIT = 1;

    function automatic int unsigned chan_w(input int unsigned num_ch);
        int unsigned w;
        w = 1;
        if (num_ch > 2) begin
            w = $clog2(num_ch);
        end
        return w;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active period and hold, enable/polarity, tick counter,
// registered pwm level and wrap pulse.
module pwm_channel
    import pwm_timer_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEF_PERIOD = 40000,
    parameter int unsigned DEF_HOLD   = 6000,
    parameter bit          DEF_EN     = 1'b1,
    parameter bit          DEF_POL    = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_sel_i,
    input  logic [CNT_W-1:0] wr_data_i,
    output logic             pwm_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] DEF_PER_V  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_HOLD_V = CNT_W'(DEF_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] per_pend_q, per_pend_d;
    logic [CNT_W-1:0] hold_pend_q, hold_pend_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             pol_q, pol_d;
    logic             pwm_q, pwm_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] per_last;
    logic             wrap_ev;

    always_comb begin
        per_pend_d  = per_pend_q;
        hold_pend_d = hold_pend_q;
        per_d       = per_q;
        hold_d      = hold_q;
        en_d        = en_q;
        pol_d       = pol_q;
        cnt_d       = cnt_q;

        // period 0 behaves as period 1
        per_last = (per_q == '0) ? '0 : per_q - CNT_ONE;
        wrap_ev  = tick_i && en_q && (cnt_q >= per_last);

        if (wr_en_i) begin
            case (wr_sel_e'(wr_sel_i))
                WR_SEL_PERIOD: per_pend_d  = wr_data_i;
                WR_SEL_HOLD:   hold_pend_d = wr_data_i;
                WR_SEL_CTRL: begin
                    en_d  = wr_data_i[CTRL_EN_BIT];
                    pol_d = wr_data_i[CTRL_POL_BIT];
                end
                default: ;
            endcase
        end

        // Active copies read the pending registers as they were before this clk's write.
        if (wrap_ev || !en_q) begin
            per_d  = per_pend_q;
            hold_d = hold_pend_q;
        end

        if (!en_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = wrap_ev ? '0 : cnt_q + CNT_ONE;
        end

        pwm_d  = (en_q && (cnt_q < hold_q)) ? pol_q : ~pol_q;
        wrap_d = wrap_ev;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_pend_q  <= DEF_PER_V;
            hold_pend_q <= DEF_HOLD_V;
            per_q       <= DEF_PER_V;
            hold_q      <= DEF_HOLD_V;
            en_q        <= DEF_EN;
            pol_q       <= DEF_POL;
            cnt_q       <= '0;
            pwm_q       <= ~DEF_POL;
            wrap_q      <= 1'b0;
        end else begin
            per_pend_q  <= per_pend_d;
            hold_pend_q <= hold_pend_d;
            per_q       <= per_d;
            hold_q      <= hold_d;
            en_q        <= en_d;
            pol_q       <= pol_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            wrap_q      <= wrap_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/pwm_timer_bank.sv
// Multi-channel PWM timer bank: shared tick prescaler, write-address decode and
// NUM_CH independent pwm_channel instances.
module pwm_timer_bank
    import pwm_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_TICKS = 600,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEF_PERIOD     = 40000,
    parameter int unsigned DEF_HOLD       = 6000,
    parameter bit          DEF_EN         = 1'b1,
    parameter bit          DEF_POL        = 1'b1,
    localparam int unsigned CH_W          = chan_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    output logic              tick,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] wrap
);

    localparam int unsigned     PS_W    = $clog2(PRESCALE_TICKS);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_TICKS - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] ps_q, ps_d;

    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PS_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HOLD   (DEF_HOLD),
            .DEF_EN     (DEF_EN),
            .DEF_POL    (DEF_POL)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (reset),
            .tick_i    (tick),
            .wr_en_i   (wr_en && (wr_ch == CH_W'(i))),
            .wr_sel_i  (wr_sel),
            .wr_data_i (wr_data),
            .pwm_o     (pwm[i]),
            .wrap_o    (wrap[i])
        );
    end

endmodule

// File: tb/tb_pwm_timer_bank.sv
// Directed bench for pwm_timer_bank: 4-clk tick, 2 channels, 8-bit counters,
// default period 5 / hold 2; samples on the falling edge into per-cycle logs.
module tb_pwm_timer_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       wr_ch;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       tick;
    logic [1:0] pwm;
    logic [1:0] wrap;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned k;

    logic [1:0] pwm_log  [0:511];
    logic [1:0] wrap_log [0:511];
    logic       tick_log [0:511];

    pwm_timer_bank #(
        .PRESCALE_TICKS (4),
        .NUM_CH         (2),
        .CNT_W          (8),
        .DEF_PERIOD     (5),
        .DEF_HOLD       (2),
        .DEF_EN         (1'b1),
        .DEF_POL        (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .tick    (tick),
        .pwm     (pwm),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // A write driven after one sample is held for exactly one clk: the next step drops it.
    task automatic step();
        @(negedge clk);
        wr_en = 1'b0;
        k++;
        pwm_log[k]  = pwm;
        wrap_log[k] = wrap;
        tick_log[k] = tick;
    endtask

    task automatic run_to(input int unsigned target);
        while (k < target) step();
    endtask

    task automatic write_reg(input int unsigned ch, input int unsigned sel, input int unsigned data);
        wr_en   = 1'b1;
        wr_ch   = ch[0];
        wr_sel  = sel[1:0];
        wr_data = data[7:0];
    endtask

    function automatic int unsigned count_pwm(input int unsigned ch, input int unsigned lo,
                                              input int unsigned hi);
        int unsigned n = 0;
        for (int unsigned j = lo; j <= hi; j++) if (pwm_log[j][ch]) n++;
        return n;
    endfunction

    function automatic int unsigned count_wrap(input int unsigned ch, input int unsigned lo,
                                               input int unsigned hi);
        int unsigned n = 0;
        for (int unsigned j = lo; j <= hi; j++) if (wrap_log[j][ch]) n++;
        return n;
    endfunction

    function automatic int unsigned count_tick(input int unsigned lo, input int unsigned hi);
        int unsigned n = 0;
        for (int unsigned j = lo; j <= hi; j++) if (tick_log[j]) n++;
        return n;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_ch   = 1'b0;
        wr_sel  = 2'd0;
        wr_data = 8'd0;
        k       = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_pwm",  pwm,  0);
        check_eq("rst_wrap", wrap, 0);
        reset = 1'b0;

        // 1: default waveform
        run_to(40);
        check_eq("t1_no_early_tick", count_tick(1, 2), 0);
        check_eq("t1_first_tick",    tick_log[3], 1);
        check_eq("t1_ticks",         count_tick(1, 40), 10);
        check_eq("t1_act_ch0",       count_pwm(0, 1, 20), 8);
        check_eq("t1_act_ch1",       count_pwm(1, 21, 40), 8);
        check_eq("t1_pwm_k8",        pwm_log[8][0], 1);
        check_eq("t1_pwm_k9",        pwm_log[9][0], 0);
        check_eq("t1_wrap_k20",      wrap_log[20], 3);
        check_eq("t1_wraps",         count_wrap(0, 1, 40), 2);

        // 2: mid-period hold write
        run_to(45);
        write_reg(0, 1, 3);
        run_to(80);
        check_eq("t2_cur_period",  count_pwm(0, 41, 60), 8);
        check_eq("t2_next_period", count_pwm(0, 61, 80), 12);
        check_eq("t2_ch1_same",    count_pwm(1, 61, 80), 8);

        // 3: write in the wrap clk
        run_to(99);
        write_reg(0, 1, 1);
        run_to(140);
        check_eq("t3_wrap_k100",   wrap_log[100][0], 1);
        check_eq("t3_old_pending", count_pwm(0, 101, 120), 12);
        check_eq("t3_new_value",   count_pwm(0, 121, 140), 4);

        // 4: disable ch1 mid-period
        run_to(142);
        check_eq("t4_pwm1_before", pwm_log[142][1], 1);
        write_reg(1, 2, 2);
        run_to(212);
        check_eq("t4_pwm1_lag",  pwm_log[143][1], 1);
        check_eq("t4_pwm1_idle", pwm_log[144][1], 0);
        check_eq("t4_no_act",    count_pwm(1, 144, 212), 0);
        check_eq("t4_no_wrap",   count_wrap(1, 143, 212), 0);

        // 5: re-enable ch1
        write_reg(1, 2, 3);
        run_to(252);
        check_eq("t5_pwm1_k213",   pwm_log[213][1], 0);
        check_eq("t5_pwm1_k214",   pwm_log[214][1], 1);
        check_eq("t5_first_act",   count_pwm(1, 214, 232), 7);
        check_eq("t5_no_wrap_yet", count_wrap(1, 213, 231), 0);
        check_eq("t5_wrap1_k232",  wrap_log[232][1], 1);
        check_eq("t5_full_period", count_pwm(1, 233, 252), 8);
        check_eq("t5_wrap1_k240",  wrap_log[240][1], 0);
        check_eq("t5_ch0_act",     count_pwm(0, 221, 240), 4);
        check_eq("t5_ch0_wraps",   count_wrap(0, 213, 252), 2);

        // 6: boundary hold/period values, back-to-back writes, ignored select
        run_to(253);
        write_reg(0, 1, 0);
        step();
        write_reg(1, 1, 9);
        step();
        write_reg(1, 3, 0);
        run_to(281);
        write_reg(0, 0, 0);
        run_to(320);
        check_eq("t6_hold0_idle",   count_pwm(0, 261, 320), 0);
        check_eq("t6_hold9_active", count_pwm(1, 273, 320), 48);
        check_eq("t6_ch1_wraps",    count_wrap(1, 273, 320), 2);
        check_eq("t6_wrap0_k300",   wrap_log[300][0], 1);
        check_eq("t6_no_wrap_pre",  count_wrap(0, 281, 299), 0);
        check_eq("t6_per0_wraps",   count_wrap(0, 301, 320), 5);
        check_eq("t6_per0_k304",    wrap_log[304][0], 1);

        // 7: reset mid-period
        run_to(330);
        check_eq("t7_pwm_before", pwm_log[330], 2);
        #2 reset = 1'b1;
        #1;
        check_eq("t7_pwm_async",  pwm, 0);
        check_eq("t7_wrap_async", wrap, 0);
        check_eq("t7_tick_async", tick, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        run_to(40);
        check_eq("t7_first_tick", tick_log[3], 1);
        check_eq("t7_act_ch0",    count_pwm(0, 1, 20), 8);
        check_eq("t7_act_ch1",    count_pwm(1, 1, 20), 8);
        check_eq("t7_no_wrap",    count_wrap(0, 1, 19), 0);
        check_eq("t7_wrap_k20",   wrap_log[20], 3);
        check_eq("t7_ch0_p2",     count_pwm(0, 21, 40), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
